// File: rtl/weight_tile_streamer.sv
// weight_tile_streamer
//   Producer side of the GEMV weight-tile handshake. Walks a rows x cols weight
//   matrix stored one TILE_SIZE-lane tile per memory word, row-major and
//   tile-major. Reads go through a fixed-latency pipelined memory into a
//   2-entry FIFO, so that tiles can go out back-to-back.
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start                one-cycle pulse; latches rows/cols/base_addr when idle
//   rows, cols           matrix dimensions
//   base_addr            word address of row 0, tile 0
//   mem_rd_en, mem_addr  read request to the weight memory
//   mem_rd_data          read data, valid MEM_LATENCY cycles after mem_rd_en
//   w_valid, w_ready     tile handshake towards the GEMV engine
//   w_tile_row_out       tile lanes; lanes beyond the row end are zero
//   busy, done           busy while streaming; done pulses once at the end
module weight_tile_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int TILE_SIZE   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [9:0]                         rows,
    input  logic [9:0]                         cols,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    output logic                               mem_rd_en,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0]    mem_rd_data,
    output logic                               w_valid,
    input  logic                               w_ready,
    output logic signed [DATA_WIDTH-1:0]       w_tile_row_out [0:TILE_SIZE-1],
    output logic                               busy,
    output logic                               done
);

    localparam int CW = $clog2(TILE_SIZE + 1);
    localparam int OW = $clog2(MEM_LATENCY + 1) + 1;
    localparam int WW = TILE_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t           state;
    logic [9:0]       cols_q;
    logic [9:0]       col_rem;    // columns left in the current row at the issue point
    logic [19:0]      iss_left;   // tiles still to request
    logic [19:0]      del_left;   // tiles still to hand over

    logic [MEM_LATENCY-1:0] pipe_v;
    logic [CW-1:0]          pipe_n [MEM_LATENCY];

    logic [WW-1:0]    fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_count;

    logic [OW-1:0]    outstanding;
    logic             push;
    logic             pop;
    logic [CW-1:0]    issue_n;
    logic [WW-1:0]    padded;
    logic [31:0]      tpr;
    logic [31:0]      total;

    always_comb begin
        tpr   = (32'(cols) + 32'(TILE_SIZE) - 32'd1) / 32'(TILE_SIZE);
        total = 32'(rows) * tpr;
    end

    always_comb begin
        outstanding = '0;
        for (int unsigned i = 0; i < MEM_LATENCY; i++)
            outstanding = outstanding + OW'(pipe_v[i]);
    end

    assign w_valid = (fifo_count != 2'd0);
    assign pop     = w_valid && w_ready;
    assign push    = pipe_v[MEM_LATENCY-1];

    // Occupancy counts the head leaving this cycle, so a steady stream keeps
    // one tile buffered and one in flight without ever overfilling the FIFO.
    assign mem_rd_en = (state == STREAM) && (iss_left != 20'd0) &&
                       ((32'(fifo_count) + 32'(outstanding) - 32'(pop)) < 32'd2);

    assign issue_n = (32'(col_rem) >= 32'(TILE_SIZE)) ? CW'(TILE_SIZE) : CW'(col_rem);

    // Lane count travels with the request; padding is applied on return.
    always_comb begin
        padded = '0;
        for (int unsigned i = 0; i < TILE_SIZE; i++)
            if (i < 32'(pipe_n[MEM_LATENCY-1]))
                padded[i*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        for (int unsigned i = 0; i < TILE_SIZE; i++)
            w_tile_row_out[i] = w_valid ? $signed(fifo_mem[rd_ptr][i*DATA_WIDTH +: DATA_WIDTH]) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            cols_q     <= '0;
            col_rem    <= '0;
            iss_left   <= '0;
            del_left   <= '0;
            pipe_v     <= '0;
            for (int unsigned i = 0; i < MEM_LATENCY; i++)
                pipe_n[i] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            pipe_v[0] <= mem_rd_en;
            pipe_n[0] <= issue_n;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_n[i] <= pipe_n[i-1];
            end

            if (push) begin
                fifo_mem[wr_ptr] <= padded;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                del_left <= del_left - 20'd1;
            end
            fifo_count <= fifo_count + 2'(push) - 2'(pop);

            // Tiles are contiguous in memory, so the address simply counts up;
            // col_rem tracks the tile position within the row for lane counts.
            if (mem_rd_en) begin
                mem_addr <= mem_addr + 1'b1;
                iss_left <= iss_left - 20'd1;
                if (32'(col_rem) <= 32'(TILE_SIZE))
                    col_rem <= cols_q;
                else
                    col_rem <= col_rem - 10'(TILE_SIZE);
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (rows != 10'd0 && cols != 10'd0) begin
                            state    <= STREAM;
                            mem_addr <= base_addr;
                            cols_q   <= cols;
                            col_rem  <= cols;
                            iss_left <= total[19:0];
                            del_left <= total[19:0];
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (pop && del_left == 20'd1) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_tile_streamer.sv
module tb_weight_tile_streamer;

    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start_a, start_b, w_ready, sel;
    logic [9:0]    rows, cols;
    logic [AW-1:0] base_addr;

    logic          rd_en_a, rd_en_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [255:0]  data_a, data_b, pack_a, pack_b;
    logic signed [7:0] tile_a [0:31];
    logic signed [7:0] tile_b [0:31];
    logic [AW-1:0] b1_addr, b2_addr;

    logic          o_rd_en, o_valid, o_busy, o_done;
    logic [AW-1:0] o_addr;
    logic [255:0]  o_pack;
    logic [255:0]  last_tile;

    int checks = 0;
    int errors = 0;

    weight_tile_streamer #(.DATA_WIDTH(8), .TILE_SIZE(32), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rows(rows), .cols(cols), .base_addr(base_addr),
        .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(data_a),
        .w_valid(valid_a), .w_ready(w_ready), .w_tile_row_out(tile_a),
        .busy(busy_a), .done(done_a));

    weight_tile_streamer #(.DATA_WIDTH(8), .TILE_SIZE(32), .ADDR_WIDTH(AW), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rows(rows), .cols(cols), .base_addr(base_addr),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(data_b),
        .w_valid(valid_b), .w_ready(w_ready), .w_tile_row_out(tile_b),
        .busy(busy_b), .done(done_b));

    function automatic logic [7:0] lane_val(input logic [15:0] a, input int i);
        logic [15:0] v;
        v = a * 16'd5 + 16'(i * 3);
        return v[7:0] | 8'h01;
    endfunction

    function automatic logic [255:0] word_of(input logic [15:0] a);
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[i*8 +: 8] = lane_val(a, i);
        return w;
    endfunction

    function automatic logic [255:0] exp_tile(input logic [15:0] a, input int t, input int c);
        logic [255:0] e;
        int n;
        n = c - t * 32;
        if (n > 32) n = 32;
        for (int i = 0; i < 32; i++) e[i*8 +: 8] = (i < n) ? lane_val(a, i) : 8'h00;
        return e;
    endfunction

    // Weight memories: latency 1 and latency 3
    always @(posedge clk) data_a <= word_of(addr_a);
    always @(posedge clk) begin
        b1_addr <= addr_b;
        b2_addr <= b1_addr;
        data_b  <= word_of(b2_addr);
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            pack_a[i*8 +: 8] = tile_a[i];
            pack_b[i*8 +: 8] = tile_b[i];
        end
    end

    assign o_rd_en = sel ? rd_en_b : rd_en_a;
    assign o_addr  = sel ? addr_b  : addr_a;
    assign o_valid = sel ? valid_b : valid_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_pack  = sel ? pack_b  : pack_a;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: w_ready always 1; mode 1: w_ready pattern 1,0,0,1
    task automatic run(input logic s, input int r, input int c, input logic [15:0] b,
                       input int mode, input int exp_first, input logic contig);
        int tpr, total, nreads, ntiles, cyc, first_hs, last_hs, done_cyc;
        logic prev_stall;
        logic [255:0] prev_data;
        tpr = (c + 31) / 32;
        total = r * tpr;
        nreads = 0; ntiles = 0; first_hs = -1; last_hs = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        sel = s; rows = 10'(r); cols = 10'(c); base_addr = b;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        cyc = 0;
        while (done_cyc < 0 && cyc < 300) begin
            w_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            #1;
            if (prev_stall) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_pack, prev_data);
            end
            if (o_rd_en) begin
                check("rd_addr", o_addr, 16'(b + 16'(nreads)));
                check("occupancy", (nreads + 1 - ntiles - ((o_valid && w_ready) ? 1 : 0)) <= 2, 1);
                nreads++;
            end
            if (o_valid && w_ready) begin
                check("tile_data", o_pack, exp_tile(16'(b + 16'(ntiles)), ntiles % tpr, c));
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                last_tile = o_pack;
                ntiles++;
            end
            prev_stall = o_valid && !w_ready;
            prev_data = o_pack;
            if (o_done) done_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        check("tile_count", ntiles, total);
        check("read_count", nreads, total);
        check("first_latency", first_hs, exp_first);
        check("done_after_last", done_cyc, last_hs + 1);
        if (contig) check("back_to_back", last_hs - first_hs, total - 1);
        #1;
        check("busy_clear", o_busy, 0);
        check("done_pulse", o_done, 0);
    endtask

    initial begin
        int n, cyc;
        logic quiet;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; w_ready = 1'b0; sel = 1'b0;
        rows = '0; cols = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rd_en_a", rd_en_a, 0);
        check("rst_valid_a", valid_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_addr_a", addr_a, 0);
        check("rst_tile_a", pack_a, 0);
        check("rst_valid_b", valid_b, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;

        // 1: 2x64 from 0x10, back-to-back
        run(1'b0, 2, 64, 16'h0010, 0, 2, 1'b1);
        // 2: 1x40, second tile zero-padded beyond lane 7
        run(1'b0, 1, 40, 16'h0100, 0, 2, 1'b1);
        check("pad_lane7", last_tile[63:56], lane_val(16'h0101, 7));
        check("pad_lane8", last_tile[71:64], 0);
        check("pad_lane31", last_tile[255:248], 0);
        // 3: 3x32 with w_ready toggling 1,0,0,1
        run(1'b0, 3, 32, 16'h0300, 1, 3, 1'b0);

        // 4: rows = 0
        @(negedge clk);
        sel = 1'b0; rows = 10'd0; cols = 10'd16; base_addr = 16'h0500; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        #1;
        check("zero_busy", busy_a, 1);
        check("zero_done", done_a, 1);
        check("zero_rd_en", rd_en_a, 0);
        check("zero_valid", valid_a, 0);
        @(negedge clk);
        #1;
        check("zero_busy_after", busy_a, 0);
        check("zero_done_after", done_a, 0);

        // 5: reset after 2nd of 6 tiles
        @(negedge clk);
        sel = 1'b0; rows = 10'd2; cols = 10'd96; base_addr = 16'h0200; start_a = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 50) begin
            #1;
            if (valid_a && w_ready) n++;
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_tile2", n, 2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_rd_en", rd_en_a, 0);
        check("abort_valid", valid_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_tile", pack_a, 0);
        check("abort_addr", addr_a, 0);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (valid_a || done_a || busy_a) quiet = 1'b0;
        end
        check("abort_quiet", quiet, 1);
        run(1'b0, 1, 32, 16'h0040, 0, 2, 1'b1);

        // 6: latency-3 memory, 4x96, base near the address wrap
        run(1'b1, 4, 96, 16'hFFF8, 0, 4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
